nios_debug_slave_sysclk_chan: RTL and testbench
===============================================

Name: nios_debug_slave_sysclk_chan

Overview:
Parametrised system-clock side of the JTAG debug slave. It synchronises update-DR and update-IR strobes from the TCK domain, captures the debug shift register and instruction, and decodes them into per-channel one-cycle action pulses. It also holds each captured command pending until the CPU debug logic acknowledges it, and counts commands dropped while one was pending. It sits between the virtual-JTAG TCK logic and the OCI/break/trace control in the CPU.

Parameters:
SR_W, 38, width of captured shift register / jdo
IR_W, 2, instruction width; channel count NCH = 2**IR_W
ACT_BIT, 34, sr bit selecting action (1) vs no-action (0); must be < SR_W
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir, >= 2
OVR_W, 8, overrun counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
ir_in  in  IR_W  instruction from TCK domain, stable while vs_udr high
sr  in  SR_W  shift register from TCK domain, stable while vs_udr high
vs_udr  in  1  update-DR level, asynchronous to clk
vs_uir  in  1  update-IR level, asynchronous to clk
act_ready  in  1  consumer accepts pending command
ovr_clr  in  1  clear overrun counter
jdo  out  SR_W  captured sr
act_ch  out  IR_W  captured channel
act_valid  out  1  command pending
take_action  out  NCH  one-hot pulse, channel act_ch, sr[ACT_BIT]=1
take_no_action  out  NCH  one-hot pulse, channel act_ch, sr[ACT_BIT]=0
uir_pulse  out  1  one-cycle pulse per update-IR
overrun_cnt  out  OVR_W  saturating dropped-command count

Behaviour:
- Reset (async assert, sync release): all outputs 0. Synchroniser and edge flops 0. State IDLE.
- Sync: vs_udr and vs_uir each pass through SYNC_STAGES flops, then one edge flop.
- udr_evt = last stage 1 and edge flop 0. uir_evt is formed the same way.
- A level already high at reset release yields one event SYNC_STAGES cycles after release.
- Latency: a vs_udr rise sampled at edge k makes udr_evt true at edge k+SYNC_STAGES-1. Captured outputs appear after edge k+SYNC_STAGES.
- States:
  - IDLE: act_valid=0.
  - PEND: act_valid=1.
- Capture, on udr_evt accepted:
  - jdo<=sr, act_ch<=ir_in, act_valid<=1.
  - For exactly one cycle, take_action[ir_in]<=sr[ACT_BIT]; take_no_action[ir_in]<=~sr[ACT_BIT]. All other pulse bits 0.
- udr_evt is accepted in IDLE, or in PEND when act_ready=1 (retire and capture in the same cycle; stay PEND; new pulse issued).
- PEND, act_ready=1, no udr_evt: go to IDLE. act_valid 0 next cycle. jdo and act_ch hold their values.
- PEND, act_ready=0, udr_evt: command is dropped.
  - jdo, act_ch and pulses unchanged.
  - overrun_cnt increments, saturating at 2**OVR_W-1.
- IDLE: act_ready is ignored.
- uir_evt:
  - uir_pulse=1 for one cycle, registered like the pulses.
  - In PEND without a same-cycle udr_evt: abort, go to IDLE, act_valid 0, no pulses.
  - Simultaneous udr_evt and uir_evt: udr processed normally (accept/drop rules), uir_pulse still asserted, no abort.
- ovr_clr: overrun_cnt<=0 next cycle. Clear beats a same-cycle increment.
- Pulse outputs are never high for two consecutive cycles.
- At most one bit is set across take_action|take_no_action.
- Reset mid-PEND: immediate return to IDLE with all outputs 0. No pulse is issued for the in-flight command.

Test Plan:
- Reset, then vs_udr 0→1 with ir_in=2'd1, sr=38'h04_0000_00AB (bit34=1) -> exactly 3 clk later: jdo=38'h04_0000_00AB, act_ch=1, act_valid=1, take_action=4'b0010 for one cycle, take_no_action=0.
- From PEND, act_ready=1 for one cycle -> act_valid 0 next cycle; jdo holds.
- Second udr rise with sr bit34=0, ir_in=3 while act_ready held 1 -> act_valid stays 1, jdo updates, take_no_action=4'b1000 one cycle.
- PEND, act_ready=0, 300 udr events -> jdo unchanged, no pulses, overrun_cnt saturates at 8'hFF. Then ovr_clr concurrent with a further drop -> overrun_cnt=0.
- PEND, vs_uir rise -> uir_pulse one cycle, act_valid 0, no action pulses. uir and udr synchronised events in the same cycle -> capture happens, uir_pulse=1, act_valid=1.
- Assert reset mid-PEND with vs_udr held 1, release -> outputs 0 during reset; one new event after SYNC_STAGES cycles; IR_W=3 build repeats the first scenario on channel 5 -> take_action=8'h20.

Source files
------------

// File: rtl/nios_debug_slave_sysclk_chan.sv
// System-clock side of the JTAG debug slave: synchronises update-DR/IR strobes,
// captures the debug shift register and instruction, and issues per-channel
// action pulses while tracking one pending command and counting dropped ones.
module nios_debug_slave_sysclk_chan #(
    parameter int unsigned SR_W        = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned ACT_BIT     = 34,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVR_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [SR_W-1:0]        sr,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic                   act_ready,
    input  logic                   ovr_clr,
    output logic [SR_W-1:0]        jdo,
    output logic [IR_W-1:0]        act_ch,
    output logic                   act_valid,
    output logic [(1<<IR_W)-1:0]   take_action,
    output logic [(1<<IR_W)-1:0]   take_no_action,
    output logic                   uir_pulse,
    output logic [OVR_W-1:0]       overrun_cnt
);

    typedef enum logic {StIdle, StPend} state_t;

    localparam logic [OVR_W-1:0] OvrMax = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_edge;
    logic                   uir_edge;
    logic                   udr_evt;
    logic                   uir_evt;
    logic                   accept;
    logic                   drop;

    // Multi-stage synchronisers plus one edge flop per strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_edge <= 1'b0;
            uir_edge <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_edge <= udr_sync[SYNC_STAGES-1];
            uir_edge <= uir_sync[SYNC_STAGES-1];
        end
    end

    // Rising-edge events and the accept/drop decision for an update-DR
    always_comb begin
        udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_edge;
        uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_edge;
        accept  = udr_evt && ((state == StIdle) || act_ready);
        drop    = udr_evt && (state == StPend) && !act_ready;
    end

    // Command FSM with registered capture, pulses and overrun counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            jdo            <= '0;
            act_ch         <= '0;
            act_valid      <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            uir_pulse      <= 1'b0;
            overrun_cnt    <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            uir_pulse      <= uir_evt;

            if (accept) begin
                // Covers both a fresh capture and retire-plus-capture in PEND
                state                  <= StPend;
                act_valid              <= 1'b1;
                jdo                    <= sr;
                act_ch                 <= ir_in;
                take_action[ir_in]     <= sr[ACT_BIT];
                take_no_action[ir_in]  <= ~sr[ACT_BIT];
            end else if ((state == StPend) && !udr_evt && (uir_evt || act_ready)) begin
                // Retire on acknowledge, or abort on a new instruction
                state     <= StIdle;
                act_valid <= 1'b0;
            end

            // Clear has priority over a same-cycle drop
            if (ovr_clr) begin
                overrun_cnt <= '0;
            end else if (drop && (overrun_cnt != OvrMax)) begin
                overrun_cnt <= overrun_cnt + OVR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nios_debug_slave_sysclk_chan.sv
// Bench for nios_debug_slave_sysclk_chan: directed plan plus randomized
// transactions checked against a transaction-level command model.
module tb_nios_debug_slave_sysclk_chan;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [2:0]  ir3;
    logic [37:0] sr;
    logic        vs_udr, vs_uir, act_ready, ovr_clr;
    logic [37:0] jdo, jdo3;
    logic [1:0]  act_ch;
    logic [2:0]  act_ch3;
    logic        act_valid, act_valid3, uir_pulse, uir_pulse3;
    logic [3:0]  take_action, take_no_action;
    logic [7:0]  ta3, tna3;
    logic [7:0]  overrun_cnt, ovr3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_pend;
    logic [37:0] m_jdo;
    logic [1:0]  m_ch;
    int          m_cnt;

    always #5 clk = ~clk;

    nios_debug_slave_sysclk_chan u_dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr),
        .vs_uir(vs_uir), .act_ready(act_ready), .ovr_clr(ovr_clr), .jdo(jdo),
        .act_ch(act_ch), .act_valid(act_valid), .take_action(take_action),
        .take_no_action(take_no_action), .uir_pulse(uir_pulse),
        .overrun_cnt(overrun_cnt)
    );

    nios_debug_slave_sysclk_chan #(.IR_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .ir_in(ir3), .sr(sr), .vs_udr(vs_udr),
        .vs_uir(vs_uir), .act_ready(act_ready), .ovr_clr(ovr_clr), .jdo(jdo3),
        .act_ch(act_ch3), .act_valid(act_valid3), .take_action(ta3),
        .take_no_action(tna3), .uir_pulse(uir_pulse3), .overrun_cnt(ovr3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eta, input logic [3:0] etna,
                             input logic euir);
        chk({tag, ".jdo"}, 64'(jdo), 64'(m_jdo));
        chk({tag, ".act_ch"}, 64'(act_ch), 64'(m_ch));
        chk({tag, ".act_valid"}, 64'(act_valid), 64'(m_pend));
        chk({tag, ".take_action"}, 64'(take_action), 64'(eta));
        chk({tag, ".take_no_action"}, 64'(take_no_action), 64'(etna));
        chk({tag, ".uir_pulse"}, 64'(uir_pulse), 64'(euir));
        chk({tag, ".overrun_cnt"}, 64'(overrun_cnt), 64'(m_cnt));
    endtask

    // One synchronised transaction: optional udr/uir rise, act_ready and
    // ovr_clr presented exactly in the cycle the events are seen.
    task automatic do_ev(input string tag, input logic udr, input logic uir,
                         input logic ready, input logic clr, input logic [1:0] ir,
                         input logic [37:0] srv);
        logic [3:0] eta, etna;
        @(negedge clk);
        ir_in = ir; sr = srv; vs_udr = udr; vs_uir = uir;
        @(negedge clk);
        @(negedge clk);
        // Event visible but not yet captured: nothing may have changed
        check_all({tag, ".early"}, 4'h0, 4'h0, 1'b0);
        act_ready = ready; ovr_clr = clr;
        @(negedge clk);
        act_ready = 1'b0; ovr_clr = 1'b0;
        eta = 4'h0; etna = 4'h0;
        if (udr && (!m_pend || ready)) begin
            m_pend = 1'b1; m_jdo = srv; m_ch = ir;
            if (srv[34]) eta = 4'(1 << ir);
            else         etna = 4'(1 << ir);
        end else if (udr) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (m_pend && (uir || ready)) begin
            m_pend = 1'b0;
        end
        if (clr) m_cnt = 0;
        check_all(tag, eta, etna, uir);
        @(negedge clk);
        check_all({tag, ".after"}, 4'h0, 4'h0, 1'b0);
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_ready(input string tag);
        @(negedge clk);
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        m_pend = 1'b0;
        check_all(tag, 4'h0, 4'h0, 1'b0);
    endtask

    function automatic logic [37:0] rnd_sr();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    initial begin
        logic [37:0] s;
        reset = 1'b1; ir_in = '0; ir3 = '0; sr = '0;
        vs_udr = 1'b0; vs_uir = 1'b0; act_ready = 1'b0; ovr_clr = 1'b0;
        m_pend = 1'b0; m_jdo = '0; m_ch = '0; m_cnt = 0;
        #1;
        check_all("reset", 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First capture on channel 1 with action bit set
        do_ev("cap1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 38'h04_0000_00AB);
        do_ready("retire");

        // Retire and capture in the same cycle
        s = rnd_sr(); s[34] = 1'b1;
        do_ev("cap2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, s);
        s = rnd_sr(); s[34] = 1'b0;
        do_ev("retcap", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, s);

        // Drops while pending: counter saturates
        for (int i = 0; i < 300; i++) begin
            do_ev("drop", 1'b1, 1'b0, 1'b0, 1'b0, 2'($urandom()), rnd_sr());
        end
        chk("sat", 64'(overrun_cnt), 64'hFF);
        do_ev("clr_drop", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, rnd_sr());

        // Abort by update-IR, then simultaneous udr/uir from IDLE
        do_ev("abort", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, rnd_sr());
        do_ev("both", 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, rnd_sr());

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: do_ev("rnd_udr", 1'b1, 1'b0, 1'($urandom()), 1'b0,
                            2'($urandom()), rnd_sr());
                2: do_ready("rnd_ready");
                3: do_ev("rnd_uir", 1'b0, 1'b1, 1'($urandom()), 1'b0,
                         2'($urandom()), rnd_sr());
                4: do_ev("rnd_both", 1'b1, 1'b1, 1'($urandom()), 1'b0,
                         2'($urandom()), rnd_sr());
                default: do_ev("rnd_clr", 1'b1, 1'b0, 1'b0, 1'b1,
                               2'($urandom()), rnd_sr());
            endcase
        end

        // Reset mid-PEND with vs_udr held high
        do_ev("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, rnd_sr());
        @(negedge clk);
        s = rnd_sr(); s[34] = 1'b1;
        ir_in = 2'd2; ir3 = 3'd5; sr = s; vs_udr = 1'b1; reset = 1'b1;
        m_pend = 1'b0; m_jdo = '0; m_ch = '0; m_cnt = 0;
        #1;
        check_all("in_rst", 4'h0, 4'h0, 1'b0);
        chk("in_rst.ta3", 64'(ta3), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("rel1", 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        check_all("rel2", 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        m_pend = 1'b1; m_jdo = s; m_ch = 2'd2;
        check_all("rel3", 4'b0100, 4'h0, 1'b0);
        chk("ch5.ta3", 64'(ta3), 64'h20);
        chk("ch5.tna3", 64'(tna3), 64'h0);
        chk("ch5.act_ch3", 64'(act_ch3), 64'd5);
        @(negedge clk);
        check_all("rel4", 4'h0, 4'h0, 1'b0);
        chk("ch5.ta3_off", 64'(ta3), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
